// File: rtl/mod_ctrl.sv
// -----------------------------------------------------------------------------
// mod_ctrl
// Control unit for a repeated-subtraction modulo datapath. After a start
// request it steps the datapath through INITIALIZE, then alternating COMPARE
// and SUBTRACT, and finally DONE. It counts the SUBTRACT cycles (the quotient)
// and reports completion, divide-by-zero and iteration-limit errors.
//
// Parameters
//   CNT_W     width of the quotient counter
//   MAX_ITER  subtraction limit; must be < 2**CNT_W
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous reset, active-high
//   start     in   1      begin an operation; only looked at in IDLE
//   abort     in   1      synchronous cancel of a busy operation
//   b_zero    in   1      divisor is zero; looked at on the accepted start cycle
//   lt_flag   in   1      datapath temp < b
//   state_o   out  2      datapath command: 0 INIT, 1 SUBTRACT, 2 COMPARE, 3 DONE/hold
//   busy      out  1      high while in INIT/CMP/SUB
//   done      out  1      one-cycle completion pulse
//   err       out  1      error level, cleared by the next accepted start
//   iter_cnt  out  CNT_W  SUBTRACT cycles issued in the current/last operation
// -----------------------------------------------------------------------------
module mod_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             b_zero,
  input  logic             lt_flag,
  output logic [1:0]       state_o,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_CMP  = 3'd2,
    S_SUB  = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] CMD_INIT = 2'd0;
  localparam logic [1:0] CMD_SUB  = 2'd1;
  localparam logic [1:0] CMD_CMP  = 2'd2;
  localparam logic [1:0] CMD_DONE = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic             err_q, err_d;
  logic [1:0]       state_o_q;
  logic             busy_q;
  logic             done_q;

  // Datapath command for each FSM state. The DONE code is a datapath hold,
  // so IDLE/FIN/ERR never disturb the datapath temp register.
  function automatic logic [1:0] cmd_of(input state_e s);
    logic [1:0] c;
    case (s)
      S_INIT:  c = CMD_INIT;
      S_CMP:   c = CMD_CMP;
      S_SUB:   c = CMD_SUB;
      default: c = CMD_DONE;
    endcase
    return c;
  endfunction

  function automatic logic busy_of(input state_e s);
    logic b;
    case (s)
      S_INIT, S_CMP, S_SUB: b = 1'b1;
      default:              b = 1'b0;
    endcase
    return b;
  endfunction

  // Next-state, quotient counter and error-flag logic.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_cnt_d = '0;
          if (b_zero) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_INIT;
            err_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (lt_flag) begin
          state_d = S_FIN;
        end else if (iter_cnt_q == MAX_CNT) begin
          // Limit reached with remainder still >= b: stop before the
          // counter could exceed MAX_ITER.
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        // The datapath subtracts during every SUB cycle, abort or not, so the
        // count tracks issued subtractions even when the operation is cancelled.
        iter_cnt_d = iter_cnt_q + CNT_W'(1);
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CMP;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, counter and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      err_q      <= err_d;
    end
  end

  // Output registers, decoded from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_o_q <= CMD_DONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_o_q <= cmd_of(state_d);
      busy_q    <= busy_of(state_d);
      done_q    <= (state_d == S_FIN);
    end
  end

  assign state_o  = state_o_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_mod_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod_ctrl
// Directed testbench for mod_ctrl with a small datapath model (temp register
// loaded on INIT, decremented by b on SUBTRACT, lt_flag = temp < b).
// MAX_ITER is set to 4 so the iteration limit can be reached quickly.
// -----------------------------------------------------------------------------
module tb_mod_ctrl;

  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             b_zero = 1'b0;
  logic             lt_flag;
  logic [1:0]       state_o;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_cnt;

  logic [15:0] a_val = 16'd0;
  logic [15:0] b_val = 16'd0;
  logic [15:0] temp;

  int vectors = 0;
  int miscompares = 0;

  mod_ctrl #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .b_zero   (b_zero),
    .lt_flag  (lt_flag),
    .state_o  (state_o),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  // Datapath model
  assign lt_flag = (temp < b_val);
  always @(posedge clk or posedge rst) begin
    if (rst) temp <= 16'd0;
    else if (state_o == 2'd0) temp <= a_val;
    else if (state_o == 2'd1) temp <= temp - b_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL reset_state_o: got %0d want 3", state_o); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (iter_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_iter: got %0d want 0", iter_cnt); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // a=10, b=3: quotient 3, remainder 1, done in cycle 9
  task automatic test_q3();
    logic [1:0] exp_s [9] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    a_val = 16'd10; b_val = 16'd3; b_zero = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      vectors++; if (state_o !== exp_s[k]) begin miscompares++; $display("FAIL q3_state cyc%0d: got %0d want %0d", k + 1, state_o, exp_s[k]); end
      vectors++; if (done !== (k == 8)) begin miscompares++; $display("FAIL q3_done cyc%0d: got %b want %b", k + 1, done, (k == 8)); end
      vectors++; if (busy !== (k < 8)) begin miscompares++; $display("FAIL q3_busy cyc%0d: got %b want %b", k + 1, busy, (k < 8)); end
      if (k == 8) begin
        vectors++; if (iter_cnt !== 16'd3) begin miscompares++; $display("FAIL q3_iter: got %0d want 3", iter_cnt); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL q3_err: got %b want 0", err); end
        vectors++; if (temp !== 16'd1) begin miscompares++; $display("FAIL q3_temp: got %0d want 1", temp); end
      end
      tick();
    end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL q3_done_after: got %b want 0", done); end
  endtask

  // a=2, b=5: quotient 0, done in cycle 3
  task automatic test_q0();
    logic [1:0] exp_s [3] = '{2'd0, 2'd2, 2'd3};
    a_val = 16'd2; b_val = 16'd5; b_zero = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (state_o !== exp_s[k]) begin miscompares++; $display("FAIL q0_state cyc%0d: got %0d want %0d", k + 1, state_o, exp_s[k]); end
      vectors++; if (done !== (k == 2)) begin miscompares++; $display("FAIL q0_done cyc%0d: got %b want %b", k + 1, done, (k == 2)); end
      if (k == 2) begin
        vectors++; if (iter_cnt !== 16'd0) begin miscompares++; $display("FAIL q0_iter: got %0d want 0", iter_cnt); end
        vectors++; if (temp !== 16'd2) begin miscompares++; $display("FAIL q0_temp: got %0d want 2", temp); end
      end
      tick();
    end
  endtask

  // Divide by zero, then a valid start clears err
  task automatic test_bzero();
    a_val = 16'd7; b_val = 16'd0; b_zero = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; b_zero = 1'b0;
    vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL bz_state: got %0d want 3", state_o); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bz_busy: got %b want 0", busy); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bz_err: got %b want 1", err); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL bz_done: got %b want 0", done); end
    tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bz_err_hold: got %b want 1", err); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL bz_done_idle: got %b want 0", done); end
    a_val = 16'd2; b_val = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL bz_err_clear: got %b want 0", err); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bz_busy_restart: got %b want 1", busy); end
    tick(); tick(); tick();
  endtask

  // Iteration limit (MAX_ITER=4): a=5,b=1 errors; a=4,b=1 just completes
  task automatic test_limit();
    logic [1:0] exp_s [11] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    a_val = 16'd5; b_val = 16'd1; b_zero = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      vectors++; if (state_o !== exp_s[k]) begin miscompares++; $display("FAIL lim_state cyc%0d: got %0d want %0d", k + 1, state_o, exp_s[k]); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL lim_done cyc%0d: got %b want 0", k + 1, done); end
      if (k == 10) begin
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL lim_err: got %b want 1", err); end
        vectors++; if (iter_cnt !== 16'd4) begin miscompares++; $display("FAIL lim_iter: got %0d want 4", iter_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lim_busy: got %b want 0", busy); end
      end
      tick();
    end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL lim_done_after: got %b want 0", done); end
    a_val = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      vectors++; if (state_o !== exp_s[k]) begin miscompares++; $display("FAIL edge_state cyc%0d: got %0d want %0d", k + 1, state_o, exp_s[k]); end
      vectors++; if (done !== (k == 10)) begin miscompares++; $display("FAIL edge_done cyc%0d: got %b want %b", k + 1, done, (k == 10)); end
      if (k == 10) begin
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL edge_err: got %b want 0", err); end
        vectors++; if (iter_cnt !== 16'd4) begin miscompares++; $display("FAIL edge_iter: got %0d want 4", iter_cnt); end
        vectors++; if (temp !== 16'd0) begin miscompares++; $display("FAIL edge_temp: got %0d want 0", temp); end
      end
      tick();
    end
  endtask

  // Abort in the 2nd SUB with start held high while busy
  task automatic test_abort();
    logic [1:0] exp_s [5] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1};
    a_val = 16'd10; b_val = 16'd3; b_zero = 1'b0;
    start = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      vectors++; if (state_o !== exp_s[k]) begin miscompares++; $display("FAIL ab_state cyc%0d: got %0d want %0d", k + 1, state_o, exp_s[k]); end
      if (k == 4) begin
        abort = 1'b1;
        start = 1'b0;
      end
      tick();
    end
    abort = 1'b0;
    vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL ab_state_idle: got %0d want 3", state_o); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ab_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL ab_done: got %b want 0", done); end
    vectors++; if (iter_cnt !== 16'd2) begin miscompares++; $display("FAIL ab_iter: got %0d want 2", iter_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ab_err: got %b want 0", err); end
    tick();
    vectors++; if (state_o !== 2'd3 || done !== 1'b0) begin miscompares++; $display("FAIL ab_stay: got state %0d done %b want 3/0", state_o, done); end
  endtask

  // Async reset during a COMPARE cycle
  task automatic test_async_reset();
    a_val = 16'd10; b_val = 16'd3; b_zero = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    vectors++; if (state_o !== 2'd2 || iter_cnt !== 16'd1) begin miscompares++; $display("FAIL ar_pre: got state %0d iter %0d want 2/1", state_o, iter_cnt); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (state_o !== 2'd3) begin miscompares++; $display("FAIL ar_state: got %0d want 3", state_o); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ar_busy: got %b want 0", busy); end
    vectors++; if (iter_cnt !== 16'd0) begin miscompares++; $display("FAIL ar_iter: got %0d want 0", iter_cnt); end
    vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL ar_flags: got done %b err %b want 0/0", done, err); end
    #1;
    rst = 1'b0;
    tick();
    vectors++; if (state_o !== 2'd3 || busy !== 1'b0) begin miscompares++; $display("FAIL ar_after: got state %0d busy %b want 3/0", state_o, busy); end
  endtask

  // Start held high: second operation accepted on the first IDLE after FIN
  task automatic test_back_to_back();
    logic [1:0] exp_s [7] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3};
    logic       exp_d [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    a_val = 16'd2; b_val = 16'd5; b_zero = 1'b0;
    start = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 4) start = 1'b0;
      vectors++; if (state_o !== exp_s[k]) begin miscompares++; $display("FAIL b2b_state cyc%0d: got %0d want %0d", k + 1, state_o, exp_s[k]); end
      vectors++; if (done !== exp_d[k]) begin miscompares++; $display("FAIL b2b_done cyc%0d: got %b want %b", k + 1, done, exp_d[k]); end
      tick();
    end
    vectors++; if (state_o !== 2'd3 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got state %0d busy %b want 3/0", state_o, busy); end
  endtask

  initial begin
    test_reset();
    test_q3();
    test_q0();
    test_bzero();
    test_limit();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
